// File: rtl/mac_se_timing_pkg.sv
// mac_se_timing_pkg: Mac SE video timing defaults, lock FSM states and counter width
package mac_se_timing_pkg;
    localparam int CNT_W = 10;
    localparam int H_TOTAL_DEF = 704;
    localparam int V_TOTAL_DEF = 370;
    localparam int H_DISPLAY_DEF = 512;
    localparam int V_DISPLAY_DEF = 342;
    localparam int H_TOL_DEF = 2;
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} sync_state_t;
endpackage

// File: rtl/mac_se_sync_edge.sv
// mac_se_sync_edge: sync input synchronizer, optional glitch filter (MAC_SE_SYNC_GLITCH_FILTER_EN), registered falling-edge pulse
module mac_se_sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic sync,
    output logic fall
);
    logic [1:0] meta;
    logic clean;
    logic clean_q;
    // two-flop synchronizer, preset to the idle-high level
    always_ff @(posedge clk_in or posedge reset)
        if (reset) meta <= 2'b11;
        else meta <= {meta[0], sync};
`ifdef MAC_SE_SYNC_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic held;
    assign clean = (meta[1] == hist[0] && hist[0] == hist[1]) ? meta[1] : held;
    // sample history: output only follows three consecutive equal samples
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            hist <= 2'b11;
            held <= 1'b1;
        end else begin
            hist <= {hist[0], meta[1]};
            held <= clean;
        end
`else
    assign clean = meta[1];
`endif
    // registered falling-edge detector
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            clean_q <= 1'b1;
            fall <= 1'b0;
        end else begin
            clean_q <= clean;
            fall <= clean_q & ~clean;
        end
endmodule

// File: rtl/mac_se_sync_decoder.sv
// mac_se_sync_decoder: Mac SE hsync/vsync decoder with pixel coordinates and timing lock (MAC_SE_SYNC_GLITCH_FILTER_EN enables sync glitch filter)
module mac_se_sync_decoder
    import mac_se_timing_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int H_TOL = H_TOL_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    output logic [CNT_W-1:0] x_coord,
    output logic [CNT_W-1:0] y_coord,
    output logic             active,
    output logic             locked,
    output logic             frame_start,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic [7:0]       err_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0] LEN_MIN = (CNT_W+1)'(H_TOTAL - H_TOL);
    localparam logic [CNT_W:0] LEN_MAX = (CNT_W+1)'(H_TOTAL + H_TOL);
    localparam logic [CNT_W:0] FRAME_LEN = (CNT_W+1)'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_DISPLAY);

    sync_state_t state;
    logic h_edge;
    logic v_edge;
    logic pending;
    logic seen_h;
    logic verify_bad;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic [CNT_W:0] h_meas;
    logic [CNT_W:0] v_meas;
    logic frame_evt;
    logic line_bad;
    logic frame_bad;
    logic lost;

    mac_se_sync_edge u_hsync (.clk_in(clk_in), .reset(reset), .sync(hsync), .fall(h_edge));
    mac_se_sync_edge u_vsync (.clk_in(clk_in), .reset(reset), .sync(vsync), .fall(v_edge));

    assign h_meas = {1'b0, h_count} + 1'b1;
    assign v_meas = {1'b0, v_count} + 1'b1;
    assign frame_evt = h_edge & (pending | v_edge);
    assign line_bad = h_edge & seen_h & ((h_meas < LEN_MIN) | (h_meas > LEN_MAX));
    assign frame_bad = frame_evt & (v_meas != FRAME_LEN);
    assign lost = (h_count == CNT_MAX);
    assign x_coord = h_count;
    assign y_coord = v_count;
    assign active = locked & (h_count < H_ACT) & (v_count < V_ACT);

    // line/frame counters, length measurements and the frame_start pulse
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            line_len <= '0;
            frame_lines <= '0;
            pending <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            h_count <= h_edge ? '0 : (lost ? h_count : h_count + 1'b1);
            frame_start <= frame_evt;
            pending <= frame_evt ? 1'b0 : (pending | v_edge);
            if (h_edge && seen_h) line_len <= h_meas[CNT_W-1:0];
            if (frame_evt) begin
                v_count <= '0;
                frame_lines <= v_meas[CNT_W-1:0];
            end else if (h_edge && v_count != CNT_MAX) begin
                v_count <= v_count + 1'b1;
            end
        end

    // lock FSM: one clean verified frame locks; any timing fault drops lock and is counted
    always_ff @(posedge clk_in or posedge reset)
        if (reset) begin
            state <= SEARCH;
            locked <= 1'b0;
            err_count <= '0;
            seen_h <= 1'b0;
            verify_bad <= 1'b0;
        end else begin
            seen_h <= seen_h | h_edge;
            case (state)
                SEARCH: if (frame_evt) begin
                    state <= VERIFY;
                    verify_bad <= 1'b0;
                end
                VERIFY: if (frame_evt) begin
                    if (verify_bad | line_bad | frame_bad) begin
                        state <= SEARCH;
                        seen_h <= 1'b0;
                    end else begin
                        state <= LOCKED;
                        locked <= 1'b1;
                    end
                end else begin
                    verify_bad <= verify_bad | line_bad | lost;
                end
                LOCKED: if (line_bad | frame_bad | lost) begin
                    state <= SEARCH;
                    locked <= 1'b0;
                    seen_h <= 1'b0;
                    if (err_count != 8'hff) err_count <= err_count + 8'd1;
                end
                default: begin
                    state <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
endmodule

// File: doc/mac_se_sync_decoder.md
MAC_SE_SYNC_DECODER -- requirements
Module: mac_se_sync_decoder

Interface
REQ-001 SHALL have parameters: H_TOTAL 704, expected clocks per line; V_TOTAL 370, expected lines per frame; H_DISPLAY 512, active pixels; V_DISPLAY 342, active lines; H_TOL 2, allowed line-length deviation in clocks.
REQ-002 SHALL have ports, clock and reset first: clk_in in 1 pixel clock; reset in 1 async active-high reset.
REQ-003 SHALL have ports: hsync in 1 active-low horizontal sync; vsync in 1 active-low vertical sync.
REQ-004 SHALL have ports: x_coord out 10 pixel index in line; y_coord out 10 line index in frame; active out 1 inside display window and locked.
REQ-005 SHALL have ports: locked out 1 timing verified; frame_start out 1 one-cycle pulse at line 0; line_len out 10 last measured line length; frame_lines out 10 last measured frame line count; err_count out 8 lock-loss count.

Function
REQ-006 SHALL pass hsync and vsync through a 2-flop synchronizer, then a falling-edge detector; without the filter, h_count reaches 0 exactly 3 clk_in cycles after the input hsync falling edge is first sampled.
REQ-007 SHALL clear h_count to 0 on each detected hsync falling edge, otherwise increment it, saturating at 1023.
REQ-008 SHALL latch h_count+1 into line_len on each hsync edge; first edge after reset or SEARCH entry SHALL NOT update line_len.
REQ-009 SHALL arm a pending flag on a vsync falling edge; at the next hsync edge, including one in the same cycle, SHALL latch v_count+1 into frame_lines, clear v_count to 0, clear pending, and pulse frame_start.
REQ-010 SHALL otherwise increment v_count on each hsync edge, saturating at 1023.
REQ-011 SHALL drive x_coord = h_count and y_coord = v_count, both registered.
REQ-012 SHALL assert active only when locked=1, h_count < H_DISPLAY, and v_count < V_DISPLAY.
REQ-013 SHALL implement FSM states SEARCH, VERIFY, LOCKED; locked=1 only in LOCKED.
REQ-014 SEARCH SHALL move to VERIFY on the first frame_start.
REQ-015 VERIFY SHALL move to LOCKED at the next frame_start if every measured line_len is within H_TOTAL±H_TOL and the latched frame_lines equals V_TOTAL; otherwise it SHALL return to SEARCH.
REQ-016 LOCKED SHALL move to SEARCH on any out-of-tolerance line, a frame_lines ≠ V_TOTAL, or h_count reaching 1023 (lost hsync).
REQ-017 On LOCKED→SEARCH, err_count SHALL increment and saturate at 255.
REQ-018 A tolerance failure and a frame_start in the same cycle SHALL count as a failure.

Reset
REQ-019 Reset SHALL set h_count, v_count, line_len, frame_lines, err_count, x_coord, and y_coord to 0.
REQ-020 Reset SHALL set active, locked, and frame_start to 0, select SEARCH, and clear vsync pending.
REQ-021 Reset SHALL preset synchronizer flops to 1 (sync idle high), so release during a low sync SHALL produce one edge.
REQ-022 Reset asserted mid-frame SHALL take effect immediately, asynchronously.

Configuration
REQ-023 With MAC_SE_SYNC_GLITCH_FILTER_EN defined, each synchronized sync SHALL change only after 3 consecutive equal samples, adding 2 cycles of latency (5 total).
REQ-024 Without MAC_SE_SYNC_GLITCH_FILTER_EN, no filter logic SHALL exist and the latency SHALL be 3 cycles.

Structure
REQ-025 Package mac_se_timing_pkg SHALL hold the H_/V_ timing defaults shared with the generator, the FSM state typedef, and the counter width constant (10).
REQ-026 Sub-module mac_se_sync_edge SHALL contain the synchronizer, optional filter, and falling-edge detector, instantiated once per sync input.

Verification
REQ-027 Drive the Mac SE generator pattern (704×370, sync low 64 clocks / 4 lines) → locked=1 at the second frame_start after the first; line_len=704; frame_lines=370; err_count=0.
REQ-028 In lock, one line of 707 clocks → locked falls within 1 cycle of that edge; err_count=1; after 2 clean frames, locked=1 again.
REQ-029 In lock, one line of 706 clocks → locked remains 1.
REQ-030 Hold hsync high 1100 clocks → locked falls when h_count=1023; err_count increments by 1.
REQ-031 Locked, check x=0..511 and y=0..341 → active=1; x=512 or y=342 → active=0; frame_start pulses once per frame.
REQ-032 Apply a 1-clock hsync low glitch with MAC_SE_SYNC_GLITCH_FILTER_EN defined → no h_count reset; without it → reset, locked drops, and err_count=1.
